// File: rtl/serial_pkg.sv
// Shared FSM state encodings for the bit-serial adder and its bench monitor.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full adder cell; purely combinational, no state, no flow control.
module serial_adder_fa (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic S,
   output logic Cout
);

   assign S    = A ^ B ^ Cin;
   assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder through one FA cell; done pulses WIDTH+1 cycles after start.
// No backpressure: start is accepted only in IDLE and silently dropped while busy.
module serial_adder
   import serial_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   // The bit shifted out at the bottom is never read, so only WIDTH-1 bits are kept.
   logic [WIDTH-2:0] r_sh_q, r_sh_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   logic             fa_s;
   logic             fa_co;
   logic [WIDTH-1:0] r_next;

   serial_adder_fa u_fa (
      .A    (a_sh_q[0]),
      .B    (b_sh_q[0]),
      .Cin  (carry_q),
      .S    (fa_s),
      .Cout (fa_co)
   );

   assign r_next = {fa_s, r_sh_q};

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      r_sh_d  = r_sh_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            r_sh_d  = r_next[WIDTH-1:1];
            carry_d = fa_co;
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               sum_d   = r_next;
               cout_d  = fa_co;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         r_sh_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         r_sh_q  <= r_sh_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign busy = (state_q == SHIFT) || (state_q == DONE);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial N-bit adder built around the team's single-bit FA cell. Operands load in parallel on a start pulse and shift LSB-first through one FA instance, with the carry held in a flip-flop between bits. The result is captured in a shift register and presented in parallel with a one-cycle done pulse. It is the sequential consumer stage of the FA cell and the next lab step after combinational adder verification.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk    input   1      single clock; all state changes on rising edge
rst    input   1      asynchronous, active-high reset
start  input   1      request; sampled only in IDLE
a      input   WIDTH  operand A; captured on accepted start
b      input   WIDTH  operand B; captured on accepted start
cin    input   1      carry-in; captured on accepted start
busy   output  1      high in SHIFT and DONE states
done   output  1      one-cycle pulse; sum/cout valid from this cycle
sum    output  WIDTH  registered result; held until next result is ready
cout   output  1      registered final carry; held with sum

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE; busy=0, done=0, sum=0, cout=0. Internal operand shift registers, carry FF, result shift register and bit counter are cleared. Partial results are discarded.
- States:
  - IDLE: if start=1 at edge k, then a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each edge:
    - FA inputs are (a_sh[0], b_sh[0], carry).
    - r_sh <= {S, r_sh[WIDTH-1:1]}.
    - carry <= Cout.
    - a_sh and b_sh shift right, filling with 0.
    - cnt <= cnt+1.
  - Exit SHIFT: on the edge where cnt==WIDTH-1 (the WIDTH-th shift), load sum <= {S, r_sh[WIDTH-1:1]} and cout <= Cout, then go to DONE.
  - DONE: done=1 for exactly this one cycle. Next edge returns to IDLE unconditionally.
- Latency: start accepted at edge k. Shifts occur at edges k+1..k+WIDTH. done is high in the cycle following edge k+WIDTH. busy is low again after edge k+WIDTH+1.
- Throughput: next start is accepted at the earliest at edge k+WIDTH+2, so one result per WIDTH+2 cycles.
- start while busy (SHIFT or DONE) is ignored; no queueing, and the captured operands are unaffected.
- a, b and cin are don't-care except at the accepting edge.
- sum/cout change only on entry to DONE. During computation they hold the previous result, or 0 after reset.
- Arithmetic: {cout,sum} == a + b + cin, computed modulo 2^(WIDTH+1); no overflow flag.
- Counter width: $clog2(WIDTH)+1 bits; no wrap inside one operation.
- Outputs busy and done are decoded from the state register. No combinational path from any input to any output.

Decomposition:
- Shared package/include serial_pkg: state encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2. This is the single source for the FSM and the bench monitor.
- One sub-module: the existing single-bit FA cell (ports A, B, Cin, S, Cout), instantiated once. All sum/carry logic goes through it; no inline adder expression.
- FSM, counter and shift registers stay in serial_adder.

Test Plan:
1. Reset mid-op: start with a=8'hAA, b=8'h55. Assert rst for 1 ns at edge k+3 → busy=0, done=0, sum=0, cout=0 immediately. No done follows.
2. WIDTH=8, a=8'h35, b=8'h4A, cin=0 → done high exactly in the cycle after edge k+8; sum=8'h7F, cout=0.
3. Carry ripple: a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
4. Ignored start: start with a=8'h10, b=8'h20, then pulse start with a=8'hF0, b=8'h0F at edge k+4 → only one done; sum=8'h30, cout=0. The previous sum is held until then.
5. Back-to-back: assert start continuously → results accepted every WIDTH+2 cycles. Each done shows the operands present at its accepting edge.
6. Exhaustive, WIDTH=4: all 512 (a, b, cin) combinations. Scoreboard checks {cout,sum}==a+b+cin and done period/latency on every operation.
